// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gate-time frequency meter; FREQ_METER_SYNC_EN adds a 2-flop sigIn synchronizer
module freq_meter #(
  parameter int BASE_SPEED = 50000000,
  parameter int GATE_DIV   = 10
) (
  input  logic        inClock,
  input  logic        reset,
  input  logic        enable,
  input  logic        sigIn,
  output logic [19:0] speed,
  output logic        valid,
  output logic        overflow,
  output logic        stalled
);

  localparam int GATE_CYCLES = BASE_SPEED / GATE_DIV;
  localparam int WW = $clog2(GATE_CYCLES);
  localparam logic [19:0] MAX20 = 20'hFFFFF;

  typedef enum logic {IDLE, GATE} state_t;

  state_t        state;
  logic          s;
  logic          prev;
  logic          rise;
  logic [WW-1:0] win_cnt;
  logic [19:0]   edge_cnt;
  logic [19:0]   total;
  logic [31:0]   prod;
  logic          win_close;

`ifdef FREQ_METER_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge inClock) begin
    if (reset) sync <= 2'b00;
    else       sync <= {sync[0], sigIn};
  end

  assign s = sync[1];
`else
  assign s = sigIn;
`endif

  assign rise      = s & ~prev;
  assign win_close = (win_cnt == WW'(GATE_CYCLES - 1));
  // The close-cycle edge belongs to the closing window, so fold it in before scaling.
  assign total     = (rise && edge_cnt != MAX20) ? edge_cnt + 20'd1 : edge_cnt;
  assign prod      = {12'd0, total} * 32'(GATE_DIV);

  always_ff @(posedge inClock) begin
    if (reset) begin
      state    <= IDLE;
      win_cnt  <= '0;
      edge_cnt <= '0;
      prev     <= 1'b0;
      speed    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      stalled  <= 1'b0;
    end else begin
      prev  <= s;
      valid <= 1'b0;
      case (state)
        IDLE: begin
          win_cnt  <= '0;
          edge_cnt <= '0;
          if (enable) state <= GATE;
        end
        GATE: begin
          if (win_close) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
            speed    <= (prod > {12'd0, MAX20}) ? MAX20 : prod[19:0];
            overflow <= (prod > {12'd0, MAX20});
            stalled  <= (total == 20'd0);
            valid    <= 1'b1;
            if (!enable) state <= IDLE;
          end else if (!enable) begin
            state    <= IDLE;
            win_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            win_cnt  <= win_cnt + 1'b1;
            edge_cnt <= total;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - self-checking bench for freq_meter with a windowed edge-count reference model
module tb_freq_meter;

  localparam int GC   = 100;
  localparam int MAXC = 32768;
  localparam int MAX20 = 1048575;
`ifdef FREQ_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, sig;
  logic [19:0] speed;
  logic valid, ovf, stl;
  logic o_rst, o_en, o_sig;
  logic [19:0] o_speed;
  logic o_valid, o_ovf, o_stl;

  freq_meter #(.BASE_SPEED(1000), .GATE_DIV(10)) dut (
    .inClock(clk), .reset(rst), .enable(en), .sigIn(sig),
    .speed(speed), .valid(valid), .overflow(ovf), .stalled(stl));

  freq_meter #(.BASE_SPEED(4000000), .GATE_DIV(1000)) dut_ovf (
    .inClock(clk), .reset(o_rst), .enable(o_en), .sigIn(o_sig),
    .speed(o_speed), .valid(o_valid), .overflow(o_ovf), .stalled(o_stl));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: remembers every rise, sums them over each window when it closes.
  int  gcyc = 0;
  bit  rise_log [MAXC];
  bit  m_dl0, m_dl1, m_prev, m_in_win;
  int  m_win_start;
  bit  e_valid, e_ovf, e_stl;
  int  e_speed;
  bit  prev_valid_obs;

  int wave_period = 0, wave_t0 = 0, pulse_start = -1;
  bit ov_rst = 1'b1, ov_en = 1'b0;

  bit obs_valid, obs_ovf, obs_stl;
  int obs_speed;
  bit o_obs_valid, o_obs_ovf, o_obs_stl;
  int o_obs_speed;

  int rep_speed[$], rep_off[$];
  bit rep_ovf[$], rep_stl[$];

  function automatic bit sig_fn(input int t);
    if (pulse_start >= 0) return (t >= pulse_start && t < pulse_start + 3);
    if (wave_period == 0) return 1'b0;
    if (wave_period == 1) return 1'b1;
    return ((t - wave_t0) % wave_period) < (wave_period / 2);
  endfunction

  task automatic step(input bit r, input bit e, input bit s_in);
    bit s_now, rise_now;
    int total, prod;
    @(negedge clk);
    obs_valid = valid; obs_speed = int'(speed); obs_ovf = ovf; obs_stl = stl;
    o_obs_valid = o_valid; o_obs_speed = int'(o_speed); o_obs_ovf = o_ovf; o_obs_stl = o_stl;
    chk("valid", valid, e_valid);
    chk("speed", speed, e_speed);
    chk("overflow", ovf, e_ovf);
    chk("stalled", stl, e_stl);
    if (valid) chk("valid_back_to_back", prev_valid_obs, 0);
    prev_valid_obs = valid;
    rst = r; en = e; sig = s_in;
    o_rst = ov_rst; o_en = ov_en; o_sig = gcyc[0];

    s_now    = (LAT == 0) ? s_in : m_dl1;
    rise_now = s_now & ~m_prev;
    rise_log[gcyc] = rise_now;
    e_valid = 1'b0;
    if (r) begin
      m_in_win = 1'b0; e_speed = 0; e_ovf = 1'b0; e_stl = 1'b0;
      m_dl0 = 1'b0; m_dl1 = 1'b0; m_prev = 1'b0;
    end else begin
      m_dl1 = m_dl0; m_dl0 = s_in; m_prev = s_now;
      if (!m_in_win) begin
        if (e) begin m_in_win = 1'b1; m_win_start = gcyc + 1; end
      end else if (gcyc == m_win_start + GC - 1) begin
        total = 0;
        for (int k = m_win_start; k <= gcyc; k++) total += int'(rise_log[k]);
        if (total > MAX20) total = MAX20;
        prod = total * 10;
        e_valid = 1'b1;
        e_speed = (prod > MAX20) ? MAX20 : prod;
        e_ovf   = (prod > MAX20);
        e_stl   = (total == 0);
        if (e) m_win_start = gcyc + 1;
        else   m_in_win = 1'b0;
      end else if (!e) begin
        m_in_win = 1'b0;
      end
    end
    gcyc++;
  endtask

  task automatic run_cycles(input int n, input bit e, output int nv, output int first);
    nv = 0; first = -1;
    rep_speed.delete(); rep_off.delete(); rep_ovf.delete(); rep_stl.delete();
    for (int k = 1; k <= n; k++) begin
      step(1'b0, e, sig_fn(gcyc));
      if (obs_valid) begin
        nv++;
        if (first < 0) first = k;
        rep_speed.push_back(obs_speed); rep_off.push_back(k);
        rep_ovf.push_back(obs_ovf); rep_stl.push_back(obs_stl);
      end
    end
  endtask

  task automatic restart(input int period, input int pstart);
    int nv, first;
    wave_period = period; wave_t0 = gcyc; pulse_start = -1;
    step(1'b1, 1'b0, sig_fn(gcyc));
    step(1'b1, 1'b0, sig_fn(gcyc));
    run_cycles(5, 1'b0, nv, first);
    pulse_start = pstart;
  endtask

  typedef struct {
    int period;
    int nwin;
    int exp_speed;
    bit exp_ovf;
    bit exp_stl;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int nv, first, n0, ofirst;
    int ospd;
    bit oovf, ostl;
    rst = 1'b1; en = 1'b0; sig = 1'b0;
    o_rst = 1'b1; o_en = 1'b0; o_sig = 1'b0;
    vecs[0] = '{10, 3, 100, 1'b0, 1'b0};
    vecs[1] = '{0,  2, 0,   1'b0, 1'b1};
    vecs[2] = '{1,  2, 0,   1'b0, 1'b1};
    vecs[3] = '{4,  2, 250, 1'b0, 1'b0};
    vecs[4] = '{2,  2, 500, 1'b0, 1'b0};
    @(posedge clk);

    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("reset_speed", obs_speed, 0);
    chk("reset_valid", obs_valid, 0);
    chk("reset_overflow", obs_ovf, 0);
    chk("reset_stalled", obs_stl, 0);

    for (int i = 0; i < 5; i++) begin
      restart(vecs[i].period, -1);
      step(1'b0, 1'b1, sig_fn(gcyc));
      run_cycles(vecs[i].nwin * GC + 1, 1'b1, nv, first);
      chk($sformatf("vec%0d_count", i), nv, vecs[i].nwin);
      for (int j = 0; j < rep_speed.size(); j++) begin
        chk($sformatf("vec%0d_speed", i), rep_speed[j], vecs[i].exp_speed);
        chk($sformatf("vec%0d_overflow", i), rep_ovf[j], vecs[i].exp_ovf);
        chk($sformatf("vec%0d_stalled", i), rep_stl[j], vecs[i].exp_stl);
        chk($sformatf("vec%0d_offset", i), rep_off[j], GC + 1 + GC * j);
      end
    end

    // Saturation on the second instance: 2000 edges per 4000-cycle window, x1000.
    restart(0, -1);
    ov_rst = 1'b0; ov_en = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    ofirst = -1; ospd = 0; oovf = 1'b0; ostl = 1'b1;
    for (int k = 1; k <= 4001; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (o_obs_valid && ofirst < 0) begin
        ofirst = k; ospd = o_obs_speed; oovf = o_obs_ovf; ostl = o_obs_stl;
      end
    end
    ov_en = 1'b0; ov_rst = 1'b1;
    chk("ovf_first_valid", ofirst, 4001);
    chk("ovf_speed", ospd, MAX20);
    chk("ovf_overflow", oovf, 1);
    chk("ovf_stalled", ostl, 0);

    // Enable dropped at window cycle 50, raised 20 cycles later.
    restart(10, -1);
    step(1'b0, 1'b1, sig_fn(gcyc));
    run_cycles(150, 1'b1, nv, first);
    chk("abort_pre_count", nv, 1);
    chk("abort_pre_speed", obs_speed, 100);
    run_cycles(20, 1'b0, nv, first);
    chk("abort_no_valid", nv, 0);
    chk("abort_speed_hold", obs_speed, 100);
    step(1'b0, 1'b1, sig_fn(gcyc));
    run_cycles(101, 1'b1, nv, first);
    chk("abort_reenable_first", first, GC + 1);
    chk("abort_reenable_speed", obs_speed, 100);

    // Single edge on the close cycle, then one cycle after it.
    for (int off = 0; off < 2; off++) begin
      restart(0, -1);
      n0 = gcyc;
      step(1'b0, 1'b1, 1'b0);
      pulse_start = n0 + GC + off - LAT;
      run_cycles(2 * GC + 1, 1'b1, nv, first);
      chk($sformatf("edge%0d_count", off), nv, 2);
      if (rep_speed.size() >= 2) begin
        chk($sformatf("edge%0d_speed_a", off), rep_speed[0], (off == 0) ? 10 : 0);
        chk($sformatf("edge%0d_speed_b", off), rep_speed[1], (off == 0) ? 0 : 10);
      end
    end

    // Reset at window cycle 70 of the second window.
    restart(10, -1);
    step(1'b0, 1'b1, sig_fn(gcyc));
    run_cycles(170, 1'b1, nv, first);
    chk("rst_pre_speed", obs_speed, 100);
    step(1'b1, 1'b0, sig_fn(gcyc));
    run_cycles(1, 1'b0, nv, first);
    chk("rst_speed", obs_speed, 0);
    chk("rst_valid", obs_valid, 0);
    run_cycles(150, 1'b0, nv, first);
    chk("rst_no_reports", nv, 0);
    step(1'b0, 1'b1, sig_fn(gcyc));
    run_cycles(101, 1'b1, nv, first);
    chk("rst_resume_first", first, GC + 1);
    chk("rst_resume_speed", obs_speed, 100);

    // Random traffic against the model.
    restart(0, -1);
    begin
      bit e_r, s_r, r_r;
      e_r = 1'b0; s_r = 1'b0;
      for (int k = 0; k < 3000; k++) begin
        if (e_r) e_r = ($urandom_range(0, 99) != 0);
        else     e_r = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 9) < 3) s_r = ~s_r;
        r_r = ($urandom_range(0, 499) == 0);
        step(r_r, e_r, s_r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
